// File: rtl/mem_pkg.sv
// mem_pkg: shared types and sizes for the MEM-stage access controller.
//   state_t : controller FSM states (IDLE, ACCESS, DONE)
//   WORD_W  : data/address word width
//   TMO_W   : watchdog counter width (TIMEOUT_CYCLES up to 1023)
package mem_pkg;
  localparam int WORD_W = 32;
  localparam int TMO_W  = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: saturating watchdog counter for one memory access.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   clear   in   synchronous clear (held while the controller is idle)
//   enable  in   count one cycle of an outstanding access
//   limit   in   count value at which the access is considered expired
//   expired out  count has reached limit
module mem_timeout_cnt
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {TMO_W{1'b1}})) begin
      count <= count + TMO_W'(1);
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage controller turning EX/MEM load/store controls
// into a req/ack data-memory transaction, stalling the pipeline (en_reg=0)
// until the access completes or the watchdog aborts it.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (adds the misalign output and
// traps unaligned accesses; when undefined, addresses are forced word-aligned).
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   MemRead, MemWrite     load/store request from EX/MEM (write wins if both)
//   Branch, zero          branch flag and ALU zero flag from EX/MEM
//   total_alu, rd2        effective address and store data from EX/MEM
//   en_reg                pipeline advance enable, 0 = stall
//   PCSrc                 branch taken (Branch & zero), combinational
//   dmem_req/we/addr/wdata registered memory request outputs
//   dmem_ack, dmem_rdata  memory completion and read data
//   rdata_out             captured load data for MEM/WB
//   misalign              (MEM_MISALIGN_TRAP_EN only) unaligned-access pulse
//   mem_done, bus_err     access-finished pulse, timeout pulse
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  input  logic              zero,
  input  logic [WORD_W-1:0] total_alu,
  input  logic [WORD_W-1:0] rd2,
  output logic              en_reg,
  output logic              PCSrc,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic [WORD_W-1:0] rdata_out,
  output logic              mem_done,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic              bus_err
);

  // Watchdog fires on the last allowed ACCESS cycle (count runs 0..limit).
  localparam logic [TMO_W-1:0] WD_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WORD_W-1:0] WORD_MASK = ~WORD_W'(3);

  state_t state;
  logic   op;
  logic   wd_expired;

  assign op     = MemRead | MemWrite;
  assign PCSrc  = Branch & zero;
  // DONE releases the pipeline for one cycle so the finished op leaves EX/MEM.
  assign en_reg = (state == DONE) || ((state == IDLE) && !op);

  mem_timeout_cnt u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .enable  (state == ACCESS),
    .limit   (WD_LIMIT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdata_out  <= '0;
      mem_done   <= 1'b0;
      bus_err    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign   <= 1'b0;
`endif
    end else begin
      mem_done <= 1'b0;
      bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (op) begin
`ifdef MEM_MISALIGN_TRAP_EN
            if (total_alu[1:0] != 2'b00) begin
              state    <= DONE;
              mem_done <= 1'b1;
              misalign <= 1'b1;
            end else
`endif
            begin
              state      <= ACCESS;
              dmem_req   <= 1'b1;
              dmem_we    <= MemWrite;
              dmem_addr  <= total_alu & WORD_MASK;
              dmem_wdata <= rd2;
            end
          end
        end
        ACCESS: begin
          // An ack on the watchdog's last cycle takes priority over the abort.
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            mem_done <= 1'b1;
            if (!dmem_we) rdata_out <= dmem_rdata;
          end else if (wd_expired) begin
            state     <= DONE;
            dmem_req  <= 1'b0;
            mem_done  <= 1'b1;
            bus_err   <= 1'b1;
            rdata_out <= '0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized bench for mem_access_ctrl.
// The reference model predicts, per transaction, the stall length, number of
// request cycles, completion flags and load data from the access rules alone.
module tb_mem_access_ctrl;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, Branch, zero;
  logic [31:0] total_alu, rd2;
  logic        en_reg, PCSrc, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata, rdata_out;
  logic        mem_done, bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rdata = 32'h0;
  bit          prev_done = 1'b0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Branch     (Branch),
    .zero       (zero),
    .total_alu  (total_alu),
    .rd2        (rd2),
    .en_reg     (en_reg),
    .PCSrc      (PCSrc),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .rdata_out  (rdata_out),
    .mem_done   (mem_done),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign   (misalign),
`endif
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One EX/MEM op; k = ack wait cycles (k >= T means the memory never acks).
  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic run_op(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wd, input int k, input logic [31:0] rdat,
                        input bit br, input bit zr);
    int          stall, reqc, exp_stall, exp_reqc;
    bit          timeout, mis;
    logic [31:0] exp_addr;
    MemWrite  = wr;
    MemRead   = rd;
    total_alu = addr;
    rd2       = wd;
    Branch    = br;
    zero      = zr;
    dmem_ack  = 1'b0;
    if (prev_done) @(negedge clk);
    mis = 1'b0;
    exp_addr = {addr[31:2], 2'b00};
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (addr[1:0] != 2'b00);
`endif
    timeout   = !mis && (k >= T);
    exp_stall = mis ? 1 : (timeout ? T + 1 : 2 + k);
    exp_reqc  = mis ? 0 : (timeout ? T : k + 1);
    stall = 0;
    reqc  = 0;
    while (1) begin
      #1;
      chk1("pcsrc", PCSrc, br & zr);
      if (en_reg) break;
      if (stall > 200) begin
        chk32("stall_bound", 32'(stall), 32'(exp_stall));
        break;
      end
      stall++;
      chk1("done_early", mem_done, 1'b0);
      chk32("rdata_hold", rdata_out, exp_rdata);
      if (dmem_req) begin
        reqc++;
        chk1("we", dmem_we, wr);
        chk32("addr", dmem_addr, exp_addr);
        chk32("wdata", dmem_wdata, wd);
      end
      dmem_ack   = dmem_req && (reqc - 1 == k);
      dmem_rdata = dmem_ack ? rdat : $urandom();
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    if (!mis) begin
      if (timeout) exp_rdata = 32'h0;
      else if (!wr) exp_rdata = rdat;
    end
    chk32("stall", 32'(stall), 32'(exp_stall));
    chk32("req_cycles", 32'(reqc), 32'(exp_reqc));
    chk1("mem_done", mem_done, 1'b1);
    chk1("bus_err", bus_err, timeout);
    chk1("req_off", dmem_req, 1'b0);
    chk32("rdata_out", rdata_out, exp_rdata);
`ifdef MEM_MISALIGN_TRAP_EN
    chk1("misalign", misalign, mis);
`endif
    prev_done = 1'b1;
  endtask

  // One cycle with no op; an ack here must be ignored.
  task automatic idle_cycle(input bit ack);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    dmem_ack = ack;
    @(negedge clk);
    #1;
    dmem_ack = 1'b0;
    chk1("idle_req", dmem_req, 1'b0);
    chk1("idle_done", mem_done, 1'b0);
    chk1("idle_en", en_reg, 1'b1);
    chk32("idle_rdata", rdata_out, exp_rdata);
    prev_done = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    {MemRead, MemWrite, Branch, zero, dmem_ack} = '0;
    total_alu = '0; rd2 = '0; dmem_rdata = '0;
    #12;
    chk1("rst_req", dmem_req, 1'b0);
    chk1("rst_we", dmem_we, 1'b0);
    chk32("rst_addr", dmem_addr, 32'h0);
    chk32("rst_wdata", dmem_wdata, 32'h0);
    chk32("rst_rdata", rdata_out, 32'h0);
    chk1("rst_done", mem_done, 1'b0);
    chk1("rst_err", bus_err, 1'b0);
    chk1("rst_en", en_reg, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    idle_cycle(1'b0);

    // Zero-wait load, 3-wait store, timeout, ack on timeout cycle.
    run_op(0, 1, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF, 0, 0);
    idle_cycle(1'b0);
    run_op(1, 0, 32'h0000_0020, 32'h1234_5678, 3, 32'h5555_AAAA, 0, 0);
    run_op(0, 1, 32'h0000_0030, 32'h0, 99, 32'h1111_1111, 0, 0);
    run_op(0, 1, 32'h0000_0040, 32'h0, T - 1, 32'hCAFE_F00D, 0, 0);
    // Branch during stalled load, then back-to-back identical loads.
    run_op(0, 1, 32'h0000_0044, 32'h0, 2, 32'hA5A5_0001, 1, 1);
    run_op(0, 1, 32'h0000_0048, 32'h0, 1, 32'hA5A5_0002, 1, 0);
    run_op(0, 1, 32'h0000_0048, 32'h0, 1, 32'hA5A5_0003, 0, 1);
    // Both controls high acts as a store; unaligned address.
    run_op(1, 1, 32'h0000_0050, 32'h0BAD_C0DE, 0, 32'h7777_7777, 0, 0);
    run_op(0, 1, 32'h0000_0013, 32'h0, 0, 32'h1357_9BDF, 0, 0);
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Reset asserted in the middle of an access.
    MemRead = 1'b1; MemWrite = 1'b0; total_alu = 32'h0000_0060;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("pre_rst_req", dmem_req, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk1("mid_rst_req", dmem_req, 1'b0);
    chk1("mid_rst_done", mem_done, 1'b0);
    chk32("mid_rst_rdata", rdata_out, 32'h0);
    MemRead = 1'b0;
    #1;
    chk1("mid_rst_idle", en_reg, 1'b1);
    exp_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    idle_cycle(1'b0);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      bit          wr, rd;
      logic [31:0] a, d, r;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = $urandom();
      d  = $urandom();
      r  = $urandom();
      run_op(wr, rd, a, d, int'($urandom_range(0, 5)), r,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end
    idle_cycle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage consumer of the EX/MEM pipeline register outputs. Turns the latched MemRead/MemWrite controls, ALU address and store data into a req/ack transaction on the data-memory port, and drives the EX/MEM `en_reg` low to stall the pipeline until the access completes. Also resolves the branch decision, captures load data for MEM/WB, and bounds every access with a watchdog timeout.

## Interface
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles without `dmem_ack` before the access is aborted (legal range 1..1023).
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemRead  in  1  load request from EX/MEM.
- MemWrite  in  1  store request from EX/MEM.
- Branch  in  1  branch instruction flag from EX/MEM.
- zero  in  1  ALU zero flag from EX/MEM.
- total_alu  in  32  effective address from EX/MEM.
- rd2  in  32  store data from EX/MEM.
- en_reg  out  1  pipeline advance enable to EX/MEM and upstream registers; 0 means stall.
- PCSrc  out  1  branch taken, combinational `Branch & zero`.
- dmem_req  out  1  access request, registered.
- dmem_we  out  1  1 = write, 0 = read, registered.
- dmem_addr  out  32  access address, registered.
- dmem_wdata  out  32  store data, registered.
- dmem_ack  in  1  access complete, sampled at the rising clock edge.
- dmem_rdata  in  32  read data, valid when `dmem_ack` is high.
- rdata_out  out  32  captured load data for MEM/WB.
- mem_done  out  1  one-cycle pulse when an access finishes.
- bus_err  out  1  one-cycle pulse, coincident with `mem_done`, when the access timed out.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- Reset (rst=0, asynchronous) forces IDLE and clears all outputs: `dmem_req`, `dmem_we`, `mem_done` and `bus_err` are 0; `dmem_addr`, `dmem_wdata` and `rdata_out` are 0; the watchdog count is 0.
- IDLE, no op (MemRead=MemWrite=0): `en_reg`=1.
- IDLE, op present: `en_reg`=0 combinationally. On the next edge the FSM enters ACCESS and sets `dmem_req`=1, `dmem_we`=MemWrite, `dmem_addr`=total_alu, `dmem_wdata`=rd2.
- MemRead and MemWrite both high: treated as a write; MemRead is ignored.
- ACCESS: `en_reg`=0, and `dmem_req` and the address/data outputs are held stable.
  - On `dmem_ack`: go to DONE, `dmem_req`=0, `mem_done`=1. On a read, `rdata_out`=dmem_rdata; on a write, `rdata_out` is unchanged.
  - No ack while the watchdog count equals TIMEOUT_CYCLES-1: go to DONE, `dmem_req`=0, `mem_done`=1, `bus_err`=1, `rdata_out`=0.
  - Ack on the timeout cycle: the ack wins and `bus_err` stays 0.
- DONE: `en_reg`=1 for exactly one cycle so EX/MEM advances, then IDLE unconditionally. The op still visible at the EX/MEM outputs in DONE does not retrigger an access.
- `PCSrc` is independent of the FSM.
- `dmem_ack` outside ACCESS is ignored.

## Timing
- Zero-wait memory (ack in the first ACCESS cycle): the op is seen in cycle 0, `dmem_req` is high in cycle 1, DONE is cycle 2. Stall is 2 cycles; `en_reg` is 0 in cycles 0–1 and 1 in cycle 2.
- Ack after k wait cycles: stall is 2+k cycles.
- Timeout: `dmem_req` is high for exactly TIMEOUT_CYCLES cycles.
- Watchdog counter is 10 bits, saturating; cleared on entry to ACCESS.
- `rdata_out` is stable from DONE until the next read completes.
- Reset mid-ACCESS: `dmem_req` drops asynchronously. The memory side must tolerate an abandoned request.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Adds output `misalign  out  1`, a one-cycle pulse.
  - In IDLE, an op with `total_alu[1:0]`≠0 goes straight to DONE with no `dmem_req`, `misalign`=1 and `mem_done`=1; `rdata_out` is unchanged.
- Undefined: no `misalign` port. `dmem_addr[1:0]` is forced to 0 and all accesses are word-aligned.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE, ACCESS, DONE);
  - `WORD_W`=32;
  - watchdog counter width `TMO_W`=10.
- Sub-module `mem_timeout_cnt`: clear, enable, `limit` input and `expired` output.
- FSM and output registers live in the top module.

## Test plan
- Load at addr 0x0000_0010, ack on the first ACCESS cycle with rdata 0xDEAD_BEEF -> `en_reg` low for 2 cycles; `rdata_out`=0xDEADBEEF; `mem_done` pulses once.
- Store of rd2=0x1234_5678 to 0x0000_0020, ack after 3 wait cycles -> `dmem_we`=1 and addr/data stable for 4 cycles; `en_reg` low for 5 cycles.
- TIMEOUT_CYCLES=4, never ack -> `dmem_req` high for 4 cycles; `bus_err`=1 and `mem_done`=1 together; `rdata_out`=0.
- Ack arriving on the timeout cycle -> `bus_err`=0 and data captured. Separately, rst=0 asserted mid-ACCESS -> `dmem_req`=0 immediately and FSM in IDLE.
- Branch=1, zero=1 during a stalled load -> `PCSrc`=1 throughout. Back-to-back loads -> the second access starts only after DONE, with no duplicate access.
- With MEM_MISALIGN_TRAP_EN defined, load at 0x0000_0013 -> `misalign`=1, no `dmem_req`, 1-cycle stall.
